// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receiver.
//   state_e           : receiver FSM state encoding
//   SPI_DEFAULT_WIDTH : default frame length in bits
//   MODE0..MODE3      : SPI modes encoded as {cpol, cpha}
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_e;

  localparam int unsigned SPI_DEFAULT_WIDTH = 8;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// Single-bit synchronizer with edge detection.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input bit
//   q        : synchronized level (after SYNC_STAGES flops)
//   rise     : one-cycle pulse on synchronized 0->1 transition
//   fall     : one-cycle pulse on synchronized 1->0 transition
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    // Low SYNC_STAGES bits of {chain, d}: shift d in at the bottom.
    sync_d = SYNC_STAGES'({sync_q, d});
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver/transmitter, all SPI modes, oversampled by clk.
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   cpol, cpha        : SPI mode, latched when a frame starts
//   sck, ss, mosi     : asynchronous SPI inputs (ss active-low)
//   miso              : serial data to master, MSB first, 0 when not selected
//   tx_data, tx_load  : byte for the next frame, captured on tx_load
//   rx_data, rx_valid : received frame and its valid flag
//   rx_ready          : consumer accept for rx_data
//   busy              : slave selected and active
//   overrun           : sticky, frame dropped while rx_data unconsumed
// Optional feature: define SPI_SLAVE_OVERRUN_EN to keep unconsumed frames
// and flag overrun; otherwise new frames overwrite rx_data.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH       = SPI_DEFAULT_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             sck,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic sck_s, sck_rise, sck_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

  state_e           state_q, state_d;
  logic             cpol_q, cpol_d, cpha_q, cpha_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             miso_q, miso_d;
  logic             rx_valid_q, rx_valid_d;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic             overrun_q, overrun_d;
`endif

  logic             lead_edge, trail_edge, sample_edge, shift_edge;
  logic [WIDTH-1:0] frame;
  logic             frame_done;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk(clk), .rst(rst), .d(sck), .q(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk(clk), .rst(rst), .d(ss), .q(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  // mosi shares the sck latency so sampled data lines up with the sck edge.
  assign mosi_sync_d = SYNC_STAGES'({mosi_sync_q, mosi});
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

  // Leading edge: sck moves away from its idle level; trailing: returns to it.
  assign lead_edge   = (sck_rise | sck_fall) & (sck_s != cpol_q);
  assign trail_edge  = (sck_rise | sck_fall) & (sck_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    shift_d    = shift_q;
    tx_buf_d   = tx_buf_q;
    rx_data_d  = rx_data_q;
    cnt_d      = cnt_q;
    miso_d     = miso_q;
    rx_valid_d = rx_valid_q;
`ifdef SPI_SLAVE_OVERRUN_EN
    overrun_d  = overrun_q;
`endif
    frame      = {shift_q[WIDTH-2:0], mosi_s};
    frame_done = 1'b0;

    if (tx_load) tx_buf_d = tx_data;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      WAIT_IDLE: begin
        miso_d = 1'b0;
        cnt_d  = '0;
        if (ss_s) state_d = IDLE;
      end
      IDLE: begin
        miso_d = 1'b0;
        cnt_d  = '0;
        if (ss_fall) begin
          state_d = ACTIVE;
          cpol_d  = cpol;
          cpha_d  = cpha;
          shift_d = tx_buf_q;
          // cpha=0: master samples before any shift edge, so MSB goes out now.
          miso_d  = cpha ? 1'b0 : tx_buf_q[WIDTH-1];
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          miso_d  = 1'b0;
        end else if (sample_edge) begin
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d      = '0;
            shift_d    = tx_buf_q;
            frame_done = 1'b1;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            shift_d = frame;
          end
        end else if (shift_edge) begin
          // Register already shifted on the sample edge; its MSB is the next bit.
          miso_d = shift_q[WIDTH-1];
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    if (frame_done) begin
`ifdef SPI_SLAVE_OVERRUN_EN
      if (rx_valid_q && !rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = frame;
        rx_valid_d = 1'b1;
      end
`else
      rx_data_d  = frame;
      rx_valid_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      shift_q     <= '0;
      tx_buf_q    <= '0;
      rx_data_q   <= '0;
      cnt_q       <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      mosi_sync_q <= '0;
`ifdef SPI_SLAVE_OVERRUN_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      shift_q     <= shift_d;
      tx_buf_q    <= tx_buf_d;
      rx_data_q   <= rx_data_d;
      cnt_q       <= cnt_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      mosi_sync_q <= mosi_sync_d;
`ifdef SPI_SLAVE_OVERRUN_EN
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q == ACTIVE);
`ifdef SPI_SLAVE_OVERRUN_EN
  assign overrun  = overrun_q;
`else
  assign overrun  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
module tb_spi_slave_rx;
  import spi_pkg::*;

  localparam int H = 8;  // sck half period in clk cycles

  logic       clk = 1'b0;
  logic       rst, cpol, cpha, sck, ss, mosi, miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_load, rx_valid, rx_ready, busy, overrun;

  int n_cmp = 0;
  int n_err = 0;
  logic       seen_valid = 1'b0;
  logic [7:0] acc_q[$];

  spi_slave_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sck(sck), .ss(ss),
    .mosi(mosi), .miso(miso), .tx_data(tx_data), .tx_load(tx_load),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) seen_valid = 1'b1;
    if (!rst && rx_valid && rx_ready) acc_q.push_back(rx_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] mode;
    logic [7:0] tx;
    logic [7:0] mosi_b;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
  endtask

  task automatic ss_begin(input logic [1:0] m);
    cpol = m[1];
    cpha = m[0];
    sck  = m[1];
    wait_clk(4);
    ss = 1'b0;
    wait_clk(H);
  endtask

  task automatic ss_end();
    wait_clk(H);
    ss = 1'b1;
    wait_clk(H);
  endtask

  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] cap);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = b[7-i];
        wait_clk(H);
        c = {c[6:0], miso};
        sck = ~cpol;
        wait_clk(H);
        sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = b[7-i];
        wait_clk(H);
        c = {c[6:0], miso};
        sck = cpol;
        wait_clk(H);
      end
    end
    cap = c;
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    wait_clk(1);
  endtask

  initial begin
    logic [7:0] cap, cap2;

    vecs[0] = '{MODE0, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
    vecs[1] = '{MODE1, 8'h5A, 8'hC3, 8'hC3, 8'h5A};
    vecs[2] = '{MODE2, 8'h01, 8'h80, 8'h80, 8'h01};
    vecs[3] = '{MODE3, 8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[4] = '{MODE0, 8'h00, 8'hFF, 8'hFF, 8'h00};

    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; sck = 1'b0; ss = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_load = 1'b0; rx_ready = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(1);
    chk("reset_miso", miso, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_rx_data", rx_data, 0);
    wait_clk(4);

    // Table: one frame per mode, rx_ready low until checked.
    for (int v = 0; v < 5; v++) begin
      load_tx(vecs[v].tx);
      ss_begin(vecs[v].mode);
      xfer(vecs[v].mosi_b, 8, cap);
      ss_end();
      chk($sformatf("vec%0d_rx_valid", v), rx_valid, 1);
      chk($sformatf("vec%0d_rx_data", v), rx_data, vecs[v].exp_rx);
      chk($sformatf("vec%0d_miso_cap", v), cap, vecs[v].exp_miso);
      chk($sformatf("vec%0d_busy_idle", v), busy, 0);
      chk($sformatf("vec%0d_miso_idle", v), miso, 0);
      accept();
      chk($sformatf("vec%0d_rx_valid_clr", v), rx_valid, 0);
    end
    acc_q.delete();

    // Mode 3 back-to-back, tx_buf reloaded mid-frame applies to frame 2.
    load_tx(8'h3C);
    rx_ready = 1'b1;
    ss_begin(MODE3);
    fork
      xfer(8'h81, 8, cap);
      begin
        wait_clk(20);
        load_tx(8'h96);
      end
    join
    chk("b2b_busy_between", busy, 1);
    xfer(8'h7E, 8, cap2);
    ss_end();
    rx_ready = 1'b0;
    chk("b2b_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("b2b_frame0", acc_q[0], 8'h81);
      chk("b2b_frame1", acc_q[1], 8'h7E);
    end
    chk("b2b_miso0", cap, 8'h3C);
    chk("b2b_miso1", cap2, 8'h96);
    chk("b2b_rx_valid_end", rx_valid, 0);
    acc_q.delete();

    // Mode 1, ss raised after 5 bits; then a full frame.
    load_tx(8'h00);
    seen_valid = 1'b0;
    ss_begin(MODE1);
    xfer(8'hA8, 5, cap);
    ss_end();
    chk("abort_no_valid", seen_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_miso", miso, 0);
    ss_begin(MODE1);
    xfer(8'h55, 8, cap);
    ss_end();
    chk("after_abort_valid", rx_valid, 1);
    chk("after_abort_data", rx_data, 8'h55);
    accept();

    // rx_ready low over two frames.
    ss_begin(MODE0);
    xfer(8'h11, 8, cap);
    ss_end();
    ss_begin(MODE0);
    xfer(8'h22, 8, cap);
    ss_end();
    chk("ovr_rx_valid", rx_valid, 1);
`ifdef SPI_SLAVE_OVERRUN_EN
    chk("ovr_rx_data", rx_data, 8'h11);
    chk("ovr_flag", overrun, 1);
    accept();
    chk("ovr_sticky", overrun, 1);
`else
    chk("ovr_rx_data", rx_data, 8'h22);
    chk("ovr_flag", overrun, 0);
    accept();
    chk("ovr_sticky", overrun, 0);
`endif

    // rst pulsed mid-frame with ss held low.
    load_tx(8'hC3);
    ss_begin(MODE0);
    xfer(8'hAB, 4, cap);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    chk("rst_mid_miso", miso, 0);
    chk("rst_mid_rx_valid", rx_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_overrun", overrun, 0);
    chk("rst_mid_rx_data", rx_data, 0);
    seen_valid = 1'b0;
    xfer(8'hB0, 4, cap);
    ss_end();
    chk("rst_rest_ignored", seen_valid, 0);
    chk("rst_rest_busy", busy, 0);
    ss_begin(MODE0);
    xfer(8'hF0, 8, cap);
    ss_end();
    chk("rst_after_valid", rx_valid, 1);
    chk("rst_after_data", rx_data, 8'hF0);
    chk("rst_after_miso_cap", cap, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
